ffe_mac_datapath: RTL

FFE_MAC_DATAPATH -- requirements
Module: ffe_mac_datapath

---
 rtl/ffe_mac_datapath.sv | 123 ++++++++++++
 1 files changed

// File: rtl/ffe_mac_datapath.sv
`timescale 1ns/1ps
// Purpose: time-shared multiply-accumulate datapath for a feed-forward equaliser (one tap per cycle).
// Latency: product 1 cycle after rd_en, enters acc the next edge; y_out updates on the store edge.
// Backpressure: none; the upstream sequencer owns pacing, and idle cycles simply hold all state.
//
// Ports:
//   ffe_clk, rst                       clock, asynchronous active-high reset
//   x_in, shift_en                     sample input and delay-line shift strobe
//   rd_en, rd_addr                     request product tap[rd_addr]*coef[rd_addr]
//   str_out_n_rst_add_reg              present acc to output path and restart accumulation
//   coef_wr_en, coef_wr_addr, coef_wdata  coefficient file write port
//   y_out, y_valid, y_sat              registered saturated output, new-result pulse, clip flag
module ffe_mac_datapath #(
    parameter int DEPTH  = 4,
    parameter int DATA_W = 8,
    parameter int COEF_W = 8,
    parameter int ACC_W  = DATA_W + COEF_W + $clog2(DEPTH),
    parameter int FRAC   = 4,
    parameter int OUT_W  = 12,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic                     ffe_clk,
    input  logic                     rst,
    input  logic signed [DATA_W-1:0] x_in,
    input  logic                     shift_en,
    input  logic                     rd_en,
    input  logic        [AW-1:0]     rd_addr,
    input  logic                     str_out_n_rst_add_reg,
    input  logic                     coef_wr_en,
    input  logic        [AW-1:0]     coef_wr_addr,
    input  logic signed [COEF_W-1:0] coef_wdata,
    output logic signed [OUT_W-1:0]  y_out,
    output logic                     y_valid,
    output logic                     y_sat
);

    localparam int PROD_W = DATA_W + COEF_W;
    // Comparison width wide enough to hold both the shifted acc and the output limits.
    localparam int CMP_W  = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CMP_W-1:0] Y_MAX = CMP_W'((longint'(1) <<< (OUT_W - 1)) - 1);
    localparam logic signed [CMP_W-1:0] Y_MIN = -Y_MAX - CMP_W'(1);

    logic signed [DATA_W-1:0] taps_q [DEPTH];
    logic signed [COEF_W-1:0] coef_q [DEPTH];
    logic signed [PROD_W-1:0] prod_q, prod_d;
    logic                     prod_vld_q;
    logic signed [ACC_W-1:0]  acc_q, acc_d;
    logic signed [ACC_W-1:0]  prod_ext;
    logic signed [ACC_W-1:0]  s_w;
    logic signed [CMP_W-1:0]  s_ext;
    logic                     primed_q;
    logic signed [OUT_W-1:0]  y_out_q, y_out_d;
    logic                     y_sat_q, y_sat_d;
    logic                     y_valid_q;

    always_comb begin
        // Reads see pre-edge taps/coefs, so a same-cycle shift or write never leaks in.
        prod_d   = taps_q[rd_addr] * coef_q[rd_addr];
        prod_ext = ACC_W'(prod_q);

        acc_d = acc_q;
        if (str_out_n_rst_add_reg) begin
            acc_d = prod_vld_q ? prod_ext : '0;
        end else if (prod_vld_q) begin
            acc_d = acc_q + prod_ext;
        end

        s_w   = acc_q >>> FRAC;
        s_ext = CMP_W'(s_w);
        y_out_d = s_w[OUT_W-1:0];
        y_sat_d = 1'b0;
        if (s_ext > Y_MAX) begin
            y_out_d = Y_MAX[OUT_W-1:0];
            y_sat_d = 1'b1;
        end else if (s_ext < Y_MIN) begin
            y_out_d = Y_MIN[OUT_W-1:0];
            y_sat_d = 1'b1;
        end
    end

    always_ff @(posedge ffe_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                taps_q[i] <= '0;
                coef_q[i] <= '0;
            end
            prod_q     <= '0;
            prod_vld_q <= 1'b0;
            acc_q      <= '0;
            primed_q   <= 1'b0;
            y_out_q    <= '0;
            y_sat_q    <= 1'b0;
            y_valid_q  <= 1'b0;
        end else begin
            if (shift_en) begin
                taps_q[0] <= x_in;
                for (int i = 1; i < DEPTH; i++) begin
                    taps_q[i] <= taps_q[i-1];
                end
            end
            if (coef_wr_en) begin
                coef_q[coef_wr_addr] <= coef_wdata;
            end
            if (rd_en) begin
                prod_q <= prod_d;
            end
            prod_vld_q <= rd_en;
            acc_q      <= acc_d;
            if (str_out_n_rst_add_reg) begin
                y_out_q  <= y_out_d;
                y_sat_q  <= y_sat_d;
                primed_q <= 1'b1;
            end
            // The first store after reset only flushes a partial/empty sum, so it is not flagged.
            y_valid_q <= str_out_n_rst_add_reg & primed_q;
        end
    end

    assign y_out   = y_out_q;
    assign y_sat   = y_sat_q;
    assign y_valid = y_valid_q;

endmodule
